// File: rtl/dc_pkg.sv
// Shared state encodings and command codes for the data-cache transfer sequencer.
package dc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE           = 4'd0,
    ST_DECODE         = 4'd1,
    ST_LOAD_DATA      = 4'd2,
    ST_STORE_DATA     = 4'd3,
    ST_SENT_DATA_RBR  = 4'd4,
    ST_SENT_DATA_CBC  = 4'd5,
    ST_GET_DATA_RBR   = 4'd6,
    ST_GET_DATA_CBC   = 4'd7,
    ST_SENT_ADDR      = 4'd8,
    ST_STORE_DATA_END = 4'd10
  } dc_state_e;

  localparam logic [2:0] CMD_ROW_LOAD  = 3'd1;
  localparam logic [2:0] CMD_ROW_STORE = 3'd2;
  localparam logic [2:0] CMD_COL_LOAD  = 3'd3;
  localparam logic [2:0] CMD_COL_STORE = 3'd4;
  localparam logic [2:0] CMD_ADDR_LOAD = 3'd5;

endpackage

// File: rtl/dc_beat_cnt.sv
// Beat counter with clear/load/enable and a terminal-count flag against last_val.
module dc_beat_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] last_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear wins over load, load wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {WIDTH{1'b0}};
    end else if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == last_val);

endmodule

// File: rtl/dc_xfer_fsm.sv
// Data-cache transfer sequencer: row/column CAM bursts, DDR refill and write-back,
// address hand-off and interrupt-driven context save.
module dc_xfer_fsm
  import dc_pkg::*;
#(
  parameter int DATA_CACHE_DEPTH = 16,
  parameter int BURST_LEN        = 8,
  parameter int ADDR_WIDTH_CAM   = 8,
  parameter int CMD_WIDTH        = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          int_set,
  input  logic [CMD_WIDTH-1:0]          data_cmd,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          store_ddr_en,
  input  logic                          dc_hit,
  input  logic                          addr_ack,
  output logic                          ddr_req,
  input  logic                          ddr_ack,
  output logic [$clog2(BURST_LEN):0]    ddr_beat_idx,
  output logic                          cam_beat_en,
  output logic [ADDR_WIDTH_CAM-1:0]     cam_beat_idx,
  output logic                          int_ack,
  output logic                          done,
  output logic                          cmd_err,
  output logic [3:0]                    st_cur
);

  localparam int DDR_W = $clog2(BURST_LEN) + 1;

  dc_state_e state_q, state_d;
  logic      ret_cbc_q, ret_cbc_d;   // which SENT state a refill returns to
  logic      int_q, int_d;           // GET_DATA_CBC is servicing an interrupt
  logic      done_q, done_d;
  logic      cmd_err_q, cmd_err_d;
  logic      int_ack_q, int_ack_d;

  logic cam_clr, cam_en, cam_last;
  logic ddr_clr, ddr_en, ddr_last;

  dc_beat_cnt #(.WIDTH(ADDR_WIDTH_CAM)) u_cam_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cam_clr),
    .load     (1'b0),
    .en       (cam_en),
    .load_val ({ADDR_WIDTH_CAM{1'b0}}),
    .last_val (ADDR_WIDTH_CAM'(DATA_CACHE_DEPTH - 1)),
    .cnt      (cam_beat_idx),
    .tc       (cam_last)
  );

  dc_beat_cnt #(.WIDTH(DDR_W)) u_ddr_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (ddr_clr),
    .load     (1'b0),
    .en       (ddr_en),
    .load_val ({DDR_W{1'b0}}),
    .last_val (DDR_W'(BURST_LEN - 1)),
    .cnt      (ddr_beat_idx),
    .tc       (ddr_last)
  );

  // Next-state, counter control and pulse requests.
  always_comb begin
    state_d     = state_q;
    ret_cbc_d   = ret_cbc_q;
    int_d       = int_q;
    done_d      = 1'b0;
    cmd_err_d   = 1'b0;
    int_ack_d   = 1'b0;
    cmd_ready   = 1'b0;
    ddr_req     = 1'b0;
    cam_beat_en = 1'b0;
    cam_clr     = 1'b0;
    cam_en      = 1'b0;
    ddr_clr     = 1'b0;
    ddr_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_DECODE;
        int_d   = 1'b0;
        cam_clr = 1'b1;
        ddr_clr = 1'b1;
      end
      ST_DECODE: begin
        if (store_ddr_en) begin
          state_d = ST_STORE_DATA;
        end else begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            case (data_cmd)
              CMD_WIDTH'(CMD_ROW_LOAD):  state_d = ST_SENT_DATA_RBR;
              CMD_WIDTH'(CMD_COL_LOAD):  state_d = ST_SENT_DATA_CBC;
              CMD_WIDTH'(CMD_ROW_STORE): state_d = ST_GET_DATA_RBR;
              CMD_WIDTH'(CMD_COL_STORE): state_d = ST_GET_DATA_CBC;
              CMD_WIDTH'(CMD_ADDR_LOAD): state_d = ST_SENT_ADDR;
              default: begin
                state_d   = ST_IDLE;
                cmd_err_d = 1'b1;
              end
            endcase
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_SENT_DATA_RBR, ST_SENT_DATA_CBC: begin
        if (int_set) begin
          cam_clr = 1'b1;
          int_d   = 1'b1;
          state_d = ST_GET_DATA_CBC;
        end else if (!dc_hit) begin
          ret_cbc_d = (state_q == ST_SENT_DATA_CBC);
          ddr_clr   = 1'b1;
          state_d   = ST_LOAD_DATA;
        end else begin
          cam_beat_en = 1'b1;
          if (cam_last) begin
            cam_clr = 1'b1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cam_en = 1'b1;
          end
        end
      end
      ST_LOAD_DATA: begin
        ddr_req = 1'b1;
        if (ddr_ack) begin
          if (ddr_last) begin
            ddr_clr = 1'b1;
            state_d = ret_cbc_q ? ST_SENT_DATA_CBC : ST_SENT_DATA_RBR;
          end else begin
            ddr_en = 1'b1;
          end
        end else begin
          state_d = ST_LOAD_DATA;
        end
      end
      ST_GET_DATA_RBR, ST_GET_DATA_CBC: begin
        cam_beat_en = 1'b1;
        if (cam_last) begin
          cam_clr   = 1'b1;
          int_d     = 1'b0;
          int_ack_d = int_q;
          if (store_ddr_en) begin
            state_d = ST_STORE_DATA;
          end else begin
            done_d  = !int_q;
            state_d = ST_IDLE;
          end
        end else begin
          cam_en = 1'b1;
        end
      end
      ST_STORE_DATA: begin
        ddr_req = 1'b1;
        if (ddr_ack) begin
          if (ddr_last) begin
            ddr_clr = 1'b1;
            done_d  = 1'b1;
            state_d = ST_STORE_DATA_END;
          end else begin
            ddr_en = 1'b1;
          end
        end else begin
          state_d = ST_STORE_DATA;
        end
      end
      ST_STORE_DATA_END: begin
        state_d = ST_IDLE;
      end
      ST_SENT_ADDR: begin
        if (addr_ack) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SENT_ADDR;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cam_clr = 1'b1;
        ddr_clr = 1'b1;
      end
    endcase
  end

  // State and pulse registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ret_cbc_q <= 1'b0;
      int_q     <= 1'b0;
      done_q    <= 1'b0;
      cmd_err_q <= 1'b0;
      int_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_cbc_q <= ret_cbc_d;
      int_q     <= int_d;
      done_q    <= done_d;
      cmd_err_q <= cmd_err_d;
      int_ack_q <= int_ack_d;
    end
  end

  assign done    = done_q;
  assign cmd_err = cmd_err_q;
  assign int_ack = int_ack_q;
  assign st_cur  = state_q;

endmodule

// File: tb/tb_dc_xfer_fsm.sv
// Directed bench for dc_xfer_fsm with default parameters (depth 16, burst 8).
module tb_dc_xfer_fsm;

  logic       clk;
  logic       rst;
  logic       int_set;
  logic [2:0] data_cmd;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       store_ddr_en;
  logic       dc_hit;
  logic       addr_ack;
  logic       ddr_req;
  logic       ddr_ack;
  logic [3:0] ddr_beat_idx;
  logic       cam_beat_en;
  logic [7:0] cam_beat_idx;
  logic       int_ack;
  logic       done;
  logic       cmd_err;
  logic [3:0] st_cur;

  int errors = 0;
  int checks = 0;
  int beats  = 0;

  dc_xfer_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .int_set      (int_set),
    .data_cmd     (data_cmd),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .store_ddr_en (store_ddr_en),
    .dc_hit       (dc_hit),
    .addr_ack     (addr_ack),
    .ddr_req      (ddr_req),
    .ddr_ack      (ddr_ack),
    .ddr_beat_idx (ddr_beat_idx),
    .cam_beat_en  (cam_beat_en),
    .cam_beat_idx (cam_beat_idx),
    .int_ack      (int_ack),
    .done         (done),
    .cmd_err      (cmd_err),
    .st_cur       (st_cur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; int_set = 1'b0; data_cmd = 3'd0; cmd_valid = 1'b0;
    store_ddr_en = 1'b0; dc_hit = 1'b0; addr_ack = 1'b0; ddr_ack = 1'b0;
    step(); step(); step();
    chk("rst_st", 32'(st_cur), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_req", 32'(ddr_req), 32'd0);
    chk("rst_cam_en", 32'(cam_beat_en), 32'd0);
    chk("rst_pulses", 32'({done, int_ack, cmd_err}), 32'd0);
    chk("rst_idx", 32'({cam_beat_idx, ddr_beat_idx}), 32'd0);

    // Row load, every line resident
    rst = 1'b1; data_cmd = 3'd1; cmd_valid = 1'b1; dc_hit = 1'b1;
    step();
    chk("dec_st", 32'(st_cur), 32'd1);
    chk("dec_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    chk("rbr_st", 32'(st_cur), 32'd4);
    for (int i = 0; i < 16; i++) begin
      chk("rbr_en", 32'(cam_beat_en), 32'd1);
      chk("rbr_idx", 32'(cam_beat_idx), 32'(i));
      chk("rbr_nodone", 32'(done), 32'd0);
      step();
    end
    chk("rbr_end_st", 32'(st_cur), 32'd0);
    chk("rbr_done", 32'(done), 32'd1);
    step();
    chk("rbr_done_1cyc", 32'(done), 32'd0);
    chk("back_dec", 32'(st_cur), 32'd1);

    // Illegal command, then address hand-off
    data_cmd = 3'd6; cmd_valid = 1'b1; #1;
    chk("c6_ready", 32'(cmd_ready), 32'd1);
    step();
    data_cmd = 3'd5;
    chk("c6_st", 32'(st_cur), 32'd0);
    chk("c6_err", 32'(cmd_err), 32'd1);
    step();
    chk("c6_err_1cyc", 32'(cmd_err), 32'd0);
    step();
    cmd_valid = 1'b0; ddr_ack = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("addr_hold_st", 32'(st_cur), 32'd8);
      chk("addr_nodone", 32'(done), 32'd0);
      chk("stray_ack_req", 32'(ddr_req), 32'd0);
      chk("stray_ack_idx", 32'(ddr_beat_idx), 32'd0);
      step();
    end
    addr_ack = 1'b1; ddr_ack = 1'b0;
    step();
    addr_ack = 1'b0;
    chk("addr_st", 32'(st_cur), 32'd0);
    chk("addr_done", 32'(done), 32'd1);

    // Column load with a miss at beat 5, DDR ack every other cycle
    step();
    data_cmd = 3'd3; cmd_valid = 1'b1; #1;
    step();
    cmd_valid = 1'b0;
    chk("cbc_st", 32'(st_cur), 32'd5);
    beats = 0;
    for (int i = 0; i < 5; i++) begin
      chk("cbc_idx", 32'(cam_beat_idx), 32'(i));
      beats = beats + int'(cam_beat_en);
      step();
    end
    dc_hit = 1'b0; #1;
    chk("miss_en", 32'(cam_beat_en), 32'd0);
    chk("miss_idx", 32'(cam_beat_idx), 32'd5);
    step();
    dc_hit = 1'b1;
    chk("load_st", 32'(st_cur), 32'd2);
    chk("load_idx_kept", 32'(cam_beat_idx), 32'd5);
    for (int k = 0; k < 8; k++) begin
      ddr_ack = 1'b0; #1;
      chk("load_req", 32'(ddr_req), 32'd1);
      chk("load_ddr_idx", 32'(ddr_beat_idx), 32'(k));
      chk("load_no_cam", 32'(cam_beat_en), 32'd0);
      step();
      ddr_ack = 1'b1; #1;
      chk("load_hold_idx", 32'(ddr_beat_idx), 32'(k));
      step();
    end
    ddr_ack = 1'b0; #1;
    chk("resume_st", 32'(st_cur), 32'd5);
    chk("resume_ddr_idx", 32'(ddr_beat_idx), 32'd0);
    for (int i = 5; i < 16; i++) begin
      chk("resume_idx", 32'(cam_beat_idx), 32'(i));
      beats = beats + int'(cam_beat_en);
      step();
    end
    chk("cbc_beats", 32'(beats), 32'd16);
    chk("cbc_done", 32'(done), 32'd1);

    // Interrupt at beat 7 of a row load
    step();
    data_cmd = 3'd1; cmd_valid = 1'b1; #1;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    int_set = 1'b1; #1;
    chk("int_at_idx", 32'(cam_beat_idx), 32'd7);
    step();
    int_set = 1'b0; #1;
    chk("int_st", 32'(st_cur), 32'd7);
    chk("int_idx_clr", 32'(cam_beat_idx), 32'd0);
    for (int i = 0; i < 16; i++) begin
      int_set = (i == 3); #1;
      chk("isr_en", 32'(cam_beat_en), 32'd1);
      chk("isr_idx", 32'(cam_beat_idx), 32'(i));
      chk("isr_no_pulse", 32'({done, int_ack}), 32'd0);
      step();
    end
    int_set = 1'b0; #1;
    chk("isr_end_st", 32'(st_cur), 32'd0);
    chk("isr_int_ack", 32'(int_ack), 32'd1);
    chk("isr_no_done", 32'(done), 32'd0);

    // Write-back pending ahead of a row store
    store_ddr_en = 1'b1; data_cmd = 3'd2; cmd_valid = 1'b1;
    step();
    chk("wb_dec_ready", 32'(cmd_ready), 32'd0);
    chk("int_ack_1cyc", 32'(int_ack), 32'd0);
    step();
    store_ddr_en = 1'b0; ddr_ack = 1'b1; #1;
    for (int k = 0; k < 8; k++) begin
      chk("wb_st", 32'(st_cur), 32'd3);
      chk("wb_req", 32'(ddr_req), 32'd1);
      chk("wb_idx", 32'(ddr_beat_idx), 32'(k));
      step();
    end
    ddr_ack = 1'b0; #1;
    chk("wb_end_st", 32'(st_cur), 32'd10);
    chk("wb_end_done", 32'(done), 32'd1);
    step();
    chk("wb_idle", 32'(st_cur), 32'd0);
    chk("wb_done_1cyc", 32'(done), 32'd0);
    step();
    chk("wb_accept_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    chk("get_rbr_st", 32'(st_cur), 32'd6);
    for (int i = 0; i < 16; i++) begin
      store_ddr_en = (i == 15); #1;
      chk("get_idx", 32'(cam_beat_idx), 32'(i));
      step();
    end
    chk("get_to_wb", 32'(st_cur), 32'd3);
    chk("get_wb_nodone", 32'(done), 32'd0);

    // Reset in the middle of a write-back
    ddr_ack = 1'b1; #1;
    for (int k = 0; k < 4; k++) step();
    rst = 1'b0; #1;
    chk("mid_wb_idx", 32'(ddr_beat_idx), 32'd4);
    step();
    chk("mrst_st", 32'(st_cur), 32'd0);
    chk("mrst_outs", 32'({cmd_ready, ddr_req, cam_beat_en, int_ack, done, cmd_err}), 32'd0);
    chk("mrst_idx", 32'({cam_beat_idx, ddr_beat_idx}), 32'd0);
    rst = 1'b1; store_ddr_en = 1'b0; ddr_ack = 1'b0;
    step();
    chk("post_rst_st", 32'(st_cur), 32'd1);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dc_xfer_fsm.md
DC_XFER_FSM -- requirements
Module: dc_xfer_fsm

Interface
REQ-001 Parameter DATA_CACHE_DEPTH, default 16, number of CAM beats per row/column transfer (≥2).
REQ-002 Parameter BURST_LEN, default 8, number of DDR beats per refill/write-back burst (≥1).
REQ-003 Parameter ADDR_WIDTH_CAM, default 8, width of the CAM beat index (must be ≥ clog2(DATA_CACHE_DEPTH)).
REQ-004 Parameter CMD_WIDTH, default 3, width of data_cmd.
REQ-005 The block SHALL use one clock; reset is synchronous and active-low:
 clk  in  1  system clock, all logic on rising edge
 rst  in  1  synchronous active-low reset
 int_set  in  1  interrupt request
 data_cmd  in  CMD_WIDTH  command: 1 RowxRow_load, 2 RowxRow_store, 3 ColxCol_load, 4 ColxCol_store, 5 Addr_load
 cmd_valid  in  1  command present
 cmd_ready  out  1  command accepted this cycle when cmd_valid=1
 store_ddr_en  in  1  dirty write-back pending
 dc_hit  in  1  addressed cache line is resident
 addr_ack  in  1  address consumer accepted address
 ddr_req  out  1  DDR beat request
 ddr_ack  in  1  DDR beat accepted
 ddr_beat_idx  out  clog2(BURST_LEN)+1  current DDR beat
 cam_beat_en  out  1  CAM beat transferred this cycle
 cam_beat_idx  out  ADDR_WIDTH_CAM  current CAM row/column index
 int_ack  out  1  one-cycle pulse, interrupt context saved
 done  out  1  one-cycle pulse, command completed
 cmd_err  out  1  one-cycle pulse, illegal command
 st_cur  out  4  current state

Function
REQ-010 States/encodings SHALL be: IDLE 0, DECODE 1, LOAD_DATA 2, STORE_DATA 3, SENT_DATA_RBR 4, SENT_DATA_CBC 5, GET_DATA_RBR 6, GET_DATA_CBC 7, SENT_ADDR 8, STORE_DATA_END 10; 9, 11-15 SHALL return to IDLE.
REQ-011 IDLE SHALL go to DECODE unconditionally next cycle.
REQ-012 In DECODE with store_ddr_en=1, the FSM SHALL go to STORE_DATA with cmd_ready=0 (command held, write-back first).
REQ-013 In DECODE with store_ddr_en=0, cmd_ready SHALL be 1; on cmd_valid=1: cmd 1→SENT_DATA_RBR, 3→SENT_DATA_CBC, 2→GET_DATA_RBR, 4→GET_DATA_CBC, 5→SENT_ADDR; other codes→IDLE with cmd_err pulse; cmd_valid=0→IDLE.
REQ-014 SENT_DATA_*/GET_DATA_* SHALL assert cam_beat_en for exactly DATA_CACHE_DEPTH cycles, cam_beat_idx counting 0..DATA_CACHE_DEPTH-1, one beat per cycle.
REQ-015 In SENT_DATA_*, dc_hit=0 SHALL suppress the beat, go to LOAD_DATA, and retain cam_beat_idx and the originating state.
REQ-016 LOAD_DATA SHALL assert ddr_req; each cycle with ddr_ack=1 advances ddr_beat_idx; after BURST_LEN acked beats, return to the originating SENT state and resume at the retained index.
REQ-017 int_set=1 in SENT_DATA_* (priority over dc_hit) SHALL abort the transfer, clear cam_beat_idx, go to GET_DATA_CBC; on its completion int_ack SHALL pulse.
REQ-018 After last beat: SENT_DATA_* → IDLE with done; GET_DATA_* → STORE_DATA if store_ddr_en=1 else IDLE with done.
REQ-019 STORE_DATA SHALL issue BURST_LEN ddr_ack-qualified beats, then STORE_DATA_END for one cycle, then IDLE; done pulses in STORE_DATA_END.
REQ-020 SENT_ADDR SHALL hold until addr_ack=1, then IDLE with done.
REQ-021 ddr_req SHALL remain high until ddr_ack; ddr_ack without ddr_req SHALL be ignored.
REQ-022 Counters SHALL never wrap: terminal count forces state exit same cycle.
REQ-023 int_set outside SENT_DATA_* SHALL be ignored.

Reset
REQ-030 With rst=0 at a clock edge: st_cur=IDLE, all counters 0, cmd_ready, ddr_req, cam_beat_en, int_ack, done, cmd_err = 0, including mid-transfer; no pending state survives.

Structure
REQ-040 State encodings and command codes SHALL live in shared package dc_pkg.
REQ-041 One sub-module, dc_beat_cnt (load/clear/enable/terminal-count), SHALL be instantiated twice (CAM and DDR counters).

Verification
REQ-050 cmd 1, dc_hit=1, DEPTH 16 → 16 cam_beat_en cycles idx 0..15, done 1 cycle after beat 15, st_cur back to 0.
REQ-051 cmd 3, dc_hit=0 at idx 5, ddr_ack every 2nd cycle → 8 DDR beats, resume at idx 5, 16 total CAM beats.
REQ-052 store_ddr_en=1 with cmd 2 pending → STORE_DATA 8 beats, STORE_DATA_END, then command accepted (cmd_ready=1).
REQ-053 int_set at idx 7 of cmd 1 → GET_DATA_CBC 16 beats from idx 0, int_ack pulse, no done from SENT.
REQ-054 cmd 6 → cmd_err pulse, IDLE; cmd 5 with addr_ack after 3 cycles → done.
REQ-055 rst=0 mid-STORE_DATA beat 4 → all outputs 0, st_cur=0 next edge.
